// File: rtl/uparc_wb_stage.sv
// Write-back stage: sole driver of the register file write port.
// Registers execute results and completes one outstanding load (align + extend).
module uparc_wb_stage #(
  parameter int unsigned REG_WIDTH   = 32,
  parameter int unsigned REGNO_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   alu_valid,
  input  logic [REGNO_WIDTH-1:0] alu_rd,
  input  logic [REG_WIDTH-1:0]   alu_data,
  input  logic                   ld_req,
  input  logic [REGNO_WIDTH-1:0] ld_rd,
  input  logic [1:0]             ld_size,
  input  logic                   ld_sign,
  input  logic [1:0]             ld_offset,
  input  logic                   mem_rdy,
  input  logic                   mem_err,
  input  logic [REG_WIDTH-1:0]   mem_data,
  output logic [REGNO_WIDTH-1:0] rd,
  output logic [REG_WIDTH-1:0]   rd_data,
  output logic                   stall,
  output logic                   ld_fault
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  typedef struct packed {
    logic [REGNO_WIDTH-1:0] rd;
    logic [1:0]             size;
    logic                   sign;
    logic [1:0]             offset;
  } ld_ctx_t;

  state_t  state;
  ld_ctx_t ctx;

  logic [BYTE_W-1:0]    byte_sel_c;
  logic [HALF_W-1:0]    half_sel_c;
  logic [REG_WIDTH-1:0] ld_ext_c;

  // Big-endian lane pick and extension of the returned load word
  always_comb begin
    byte_sel_c = '0;
    half_sel_c = '0;
    ld_ext_c   = '0;

    unique case (ctx.offset)
      2'd0:    byte_sel_c = mem_data[REG_WIDTH-1 -: BYTE_W];
      2'd1:    byte_sel_c = mem_data[REG_WIDTH-1-BYTE_W -: BYTE_W];
      2'd2:    byte_sel_c = mem_data[REG_WIDTH-1-2*BYTE_W -: BYTE_W];
      default: byte_sel_c = mem_data[REG_WIDTH-1-3*BYTE_W -: BYTE_W];
    endcase

    half_sel_c = ctx.offset[1] ? mem_data[REG_WIDTH-1-HALF_W -: HALF_W]
                               : mem_data[REG_WIDTH-1 -: HALF_W];

    unique case (ctx.size)
      2'b00:   ld_ext_c = {{(REG_WIDTH-BYTE_W){ctx.sign & byte_sel_c[BYTE_W-1]}}, byte_sel_c};
      2'b01:   ld_ext_c = {{(REG_WIDTH-HALF_W){ctx.sign & half_sel_c[HALF_W-1]}}, half_sel_c};
      default: ld_ext_c = mem_data;
    endcase
  end

  // Control FSM with registered write port, stall and fault outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      ctx      <= '0;
      rd       <= '0;
      rd_data  <= '0;
      stall    <= 1'b0;
      ld_fault <= 1'b0;
    end else begin
      rd       <= '0;
      rd_data  <= '0;
      ld_fault <= 1'b0;

      unique case (state)
        IDLE: begin
          if (alu_valid && (alu_rd != '0)) begin
            rd      <= alu_rd;
            rd_data <= alu_data;
          end
          if (ld_req) begin
            ctx.rd     <= ld_rd;
            ctx.size   <= ld_size;
            ctx.sign   <= ld_sign;
            ctx.offset <= ld_offset;
            state      <= WAIT_MEM;
            stall      <= 1'b1;
          end
        end

        WAIT_MEM: begin
          // A bus error wins over a simultaneous data strobe
          if (mem_err) begin
            ld_fault <= 1'b1;
            state    <= IDLE;
            stall    <= 1'b0;
          end else if (mem_rdy) begin
            if (ctx.rd != '0) begin
              rd      <= ctx.rd;
              rd_data <= ld_ext_c;
            end
            state <= IDLE;
            stall <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uparc_wb_stage.sv
// Scoreboard bench for uparc_wb_stage: directed plan cases followed by random traffic
// against a transaction-level reference model.
module tb_uparc_wb_stage;

  logic        clk;
  logic        nrst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_req;
  logic [4:0]  ld_rd;
  logic [1:0]  ld_size;
  logic        ld_sign;
  logic [1:0]  ld_offset;
  logic        mem_rdy;
  logic        mem_err;
  logic [31:0] mem_data;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic        stall;
  logic        ld_fault;

  uparc_wb_stage #(.REG_WIDTH(32), .REGNO_WIDTH(5)) dut (
    .clk(clk), .nrst(nrst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_req(ld_req), .ld_rd(ld_rd), .ld_size(ld_size), .ld_sign(ld_sign),
    .ld_offset(ld_offset), .mem_rdy(mem_rdy), .mem_err(mem_err), .mem_data(mem_data),
    .rd(rd), .rd_data(rd_data), .stall(stall), .ld_fault(ld_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        fault;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: a pending load and its captured attributes
  bit          m_pending = 0;
  logic [4:0]  m_rd;
  logic [1:0]  m_size;
  logic        m_sign;
  logic [1:0]  m_off;
  logic        exp_stall = 0;

  function automatic logic [31:0] load_value(logic [31:0] word, logic [1:0] size,
                                             logic sign, logic [1:0] off);
    longint unsigned v;
    int unsigned     nbytes;
    int unsigned     first;
    nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    first  = (nbytes == 4) ? 0 : (nbytes == 2) ? {30'd0, off[1], 1'b0} : {30'd0, off};
    // Big-endian: byte k of the word lives at bits [31-8k -: 8]
    v = (longint'(word) >> (8 * (4 - first - nbytes))) & ((64'd1 << (8 * nbytes)) - 1);
    if (sign && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 1) == 1)
      v = v | (64'hFFFF_FFFF << (8 * nbytes));
    return 32'(v);
  endfunction

  function automatic void push_exp(logic [4:0] r, logic [31:0] d, logic f);
    exp_t e;
    e.rd = r; e.data = d; e.fault = f;
    exp_q.push_back(e);
  endfunction

  // Advance the model by one clock using the inputs seen at the edge
  function automatic void model_edge();
    if (!nrst) return;
    if (!m_pending) begin
      if (alu_valid && alu_rd != 0) push_exp(alu_rd, alu_data, 1'b0);
      if (ld_req) begin
        m_pending = 1; m_rd = ld_rd; m_size = ld_size; m_sign = ld_sign; m_off = ld_offset;
      end
    end else if (mem_err) begin
      push_exp(5'd0, 32'd0, 1'b1);
      m_pending = 0;
    end else if (mem_rdy) begin
      if (m_rd != 0) push_exp(m_rd, load_value(mem_data, m_size, m_sign, m_off), 1'b0);
      m_pending = 0;
    end
    exp_stall = m_pending;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_req = 0; ld_rd = 0; ld_size = 0; ld_sign = 0; ld_offset = 0;
    mem_rdy = 0; mem_err = 0; mem_data = 0;
  endtask

  task automatic set_alu(logic [4:0] r, logic [31:0] d);
    alu_valid = 1; alu_rd = r; alu_data = d;
  endtask

  task automatic set_ld(logic [4:0] r, logic [1:0] sz, logic sg, logic [1:0] off);
    ld_req = 1; ld_rd = r; ld_size = sz; ld_sign = sg; ld_offset = off;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation whenever the DUT presents a write or a fault
  always @(negedge clk) begin
    exp_t e;
    check("stall", 32'(stall), 32'(exp_stall));
    if (rd != 0 || ld_fault) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: rd=%0d data=0x%08h fault=%0b at %0t",
                 rd, rd_data, ld_fault, $time);
      end else begin
        e = exp_q.pop_front();
        check("rd", 32'(rd), 32'(e.rd));
        check("rd_data", rd_data, e.data);
        check("ld_fault", 32'(ld_fault), 32'(e.fault));
      end
    end else begin
      check("idle_rd_data", rd_data, 32'd0);
    end
  end

  initial begin
    clear_inputs();
    nrst = 0;
    #12;
    check("reset_rd", 32'(rd), 32'd0);
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_ld_fault", 32'(ld_fault), 32'd0);
    @(negedge clk);
    nrst = 1;
    tick();

    // ALU write
    set_alu(5'd5, 32'h1234_5678); tick(); clear_inputs(); tick(); tick();

    // Signed byte load, data returns three cycles later
    set_ld(5'd9, 2'b00, 1'b1, 2'd1); tick(); clear_inputs();
    tick(); tick();
    mem_rdy = 1; mem_data = 32'h11F0_2233; tick(); clear_inputs(); tick();

    // Unsigned half load
    set_ld(5'd10, 2'b01, 1'b0, 2'd2); tick(); clear_inputs();
    mem_rdy = 1; mem_data = 32'hAAAA_8001; tick(); clear_inputs(); tick();

    // Word load, offset ignored
    set_ld(5'd11, 2'b10, 1'b1, 2'd3); tick(); clear_inputs();
    mem_rdy = 1; mem_data = 32'hDEAD_BEEF; tick(); clear_inputs(); tick();

    // Simultaneous issue; inputs ignored while waiting
    set_alu(5'd3, 32'd7); set_ld(5'd4, 2'b10, 1'b0, 2'd0); tick(); clear_inputs();
    set_alu(5'd12, 32'hCAFE_0000); set_ld(5'd13, 2'b00, 1'b0, 2'd0); tick(); clear_inputs();
    mem_rdy = 1; mem_data = 32'h0BAD_F00D; tick(); clear_inputs(); tick();

    // Bus error has priority over data
    set_ld(5'd6, 2'b10, 1'b0, 2'd0); tick(); clear_inputs();
    mem_err = 1; mem_rdy = 1; mem_data = 32'h5555_5555; tick(); clear_inputs(); tick();

    // Load to r0 still waits for the handshake
    set_ld(5'd0, 2'b10, 1'b0, 2'd0); tick(); clear_inputs(); tick();
    mem_rdy = 1; mem_data = 32'h1111_1111; tick(); clear_inputs(); tick();

    // Reset in the middle of a load
    set_ld(5'd14, 2'b10, 1'b0, 2'd0); tick(); clear_inputs(); tick();
    nrst = 0;
    m_pending = 0; exp_stall = 0;
    #1;
    check("midreset_stall", 32'(stall), 32'd0);
    check("midreset_rd", 32'(rd), 32'd0);
    tick(); tick();
    nrst = 1;
    mem_rdy = 1; mem_data = 32'h2222_2222; tick(); clear_inputs(); tick();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      clear_inputs();
      alu_valid = ($urandom_range(0, 2) != 0);
      alu_rd    = 5'($urandom);
      alu_data  = $urandom;
      ld_req    = ($urandom_range(0, 3) == 0);
      ld_rd     = 5'($urandom);
      ld_size   = 2'($urandom);
      ld_sign   = 1'($urandom);
      ld_offset = 2'($urandom);
      mem_rdy   = ($urandom_range(0, 2) == 0);
      mem_err   = ($urandom_range(0, 9) == 0);
      mem_data  = $urandom;
      tick();
    end
    clear_inputs();
    tick(); tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
